// File: rtl/multi_ported_sram_init_ctrl_if.sv
// Bus bundle between the SRAM clients, the init controller and the SRAM ports.
// The master drives client requests; the slave (the controller) drives the SRAM side.
interface multi_ported_sram_init_ctrl_if #(
    parameter int unsigned NUM_W = 1,
    parameter int unsigned NUM_R = 1,
    parameter int unsigned W     = 32,
    parameter int unsigned N     = 8
);
    localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1;

    logic                      init;
    logic [NUM_R-1:0]          c_ren;
    logic [NUM_R*ADDR_W-1:0]   c_raddr;
    logic [NUM_W-1:0]          c_wen;
    logic [NUM_W*ADDR_W-1:0]   c_waddr;
    logic [NUM_W*W-1:0]        c_wdata;
    logic [NUM_R-1:0]          ren;
    logic [NUM_R*ADDR_W-1:0]   raddr;
    logic [NUM_W-1:0]          wen;
    logic [NUM_W*ADDR_W-1:0]   waddr;
    logic [NUM_W*W-1:0]        wdata;
    logic                      busy_w;
    logic                      done;
    logic                      drop_err;

    modport master (
        output init, c_ren, c_raddr, c_wen, c_waddr, c_wdata,
        input  ren, raddr, wen, waddr, wdata, busy_w, done, drop_err
    );

    modport slave (
        input  init, c_ren, c_raddr, c_wen, c_waddr, c_wdata,
        output ren, raddr, wen, waddr, wdata, busy_w, done, drop_err
    );
endinterface

// File: rtl/multi_ported_sram_init_ctrl.sv
// SRAM front-end: passes client traffic through when idle, otherwise sweeps every
// word with INIT_VALUE across all write ports, drains, and pulses done.
module multi_ported_sram_init_ctrl #(
    parameter int unsigned    NUM_W         = 1,
    parameter int unsigned    NUM_R         = 1,
    parameter int unsigned    W             = 32,
    parameter int unsigned    N             = 8,
    parameter logic [W-1:0]   INIT_VALUE    = '0,
    parameter bit             INIT_ON_RESET = 1'b1,
    parameter int unsigned    DRAIN_CYC     = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    multi_ported_sram_init_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned B      = (N + NUM_W - 1) / NUM_W;
    localparam int unsigned CNT_W  = $clog2(B + 1);
    localparam int unsigned DRN_W  = $clog2(DRAIN_CYC + 1);
    // Wide enough that beat*NUM_W+p never wraps on the last, partially used beat.
    localparam int unsigned EXT_W  = ADDR_W + $clog2(NUM_W) + 1;

    typedef enum logic [1:0] {StIdle, StStart, StSweep, StDrain} state_e;
    localparam state_e ResetState = INIT_ON_RESET ? StStart : StIdle;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               done_q, done_d;
    logic               drop_err_q, drop_err_d;
    logic               busy;
    logic [EXT_W-1:0]   beat_addr;

    assign busy         = (state_q != StIdle);
    assign bus.busy_w   = busy;
    assign bus.done     = done_q;
    assign bus.drop_err = drop_err_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        drop_err_d = drop_err_q;
        if (busy && ((|bus.c_ren) || (|bus.c_wen))) begin
            drop_err_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (bus.init) begin
                    state_d    = StStart;
                    drop_err_d = 1'b0;
                end
            end
            StStart: begin
                beat_d  = '0;
                state_d = StSweep;
            end
            StSweep: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == CNT_W'(B - 1)) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        bus.ren   = '0;
        bus.raddr = '0;
        bus.wen   = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        beat_addr = '0;
        case (state_q)
            StIdle: begin
                bus.ren   = bus.c_ren;
                bus.raddr = bus.c_raddr;
                bus.wen   = bus.c_wen;
                bus.waddr = bus.c_waddr;
                bus.wdata = bus.c_wdata;
            end
            StSweep: begin
                bus.wdata = {NUM_W{INIT_VALUE}};
                for (int p = 0; p < NUM_W; p++) begin
                    beat_addr = EXT_W'(beat_q) * EXT_W'(NUM_W) + EXT_W'(p);
                    if (beat_addr < EXT_W'(N)) begin
                        bus.wen[p]                    = 1'b1;
                        bus.waddr[p*ADDR_W +: ADDR_W] = beat_addr[ADDR_W-1:0];
                    end
                end
            end
            default: ;
        endcase
        // Enables must be quiet during reset even when the reset state passes through.
        if (!rst_n) begin
            bus.ren = '0;
            bus.wen = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ResetState;
            beat_q     <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            done_q     <= done_d;
            drop_err_q <= drop_err_d;
        end
    end
endmodule

// File: tb/tb_multi_ported_sram_init_ctrl.sv
// Directed bench: dut_a (N=8, 2 write ports, init on reset) and dut_b (N=6,
// 4 write ports, 2 read ports, init only on request).
module tb_multi_ported_sram_init_ctrl;
    typedef struct {
        logic [3:0]  wen;
        logic [15:0] waddr;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   checks = 0;
    int   failures = 0;
    int   n_done;
    int   first_done;
    vec_t tab_a [9];
    vec_t tab_b [7];

    localparam logic [31:0] INIT_B = 32'h5A5A_0F0F;

    always #5 clk = ~clk;

    multi_ported_sram_init_ctrl_if #(.NUM_W(2), .NUM_R(1), .W(32), .N(8)) ia ();
    multi_ported_sram_init_ctrl_if #(.NUM_W(4), .NUM_R(2), .W(32), .N(6)) ib ();

    multi_ported_sram_init_ctrl #(
        .NUM_W(2), .NUM_R(1), .W(32), .N(8), .INIT_VALUE('0), .INIT_ON_RESET(1'b1),
        .DRAIN_CYC(2)
    ) dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ia));

    multi_ported_sram_init_ctrl #(
        .NUM_W(4), .NUM_R(2), .W(32), .N(6), .INIT_VALUE(INIT_B), .INIT_ON_RESET(1'b0),
        .DRAIN_CYC(2)
    ) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ib));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tab_a(input string tag);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("%s_wen%0d", tag, i), ia.wen, tab_a[i].wen);
            chk($sformatf("%s_waddr%0d", tag, i), ia.waddr, tab_a[i].waddr);
            chk($sformatf("%s_busy%0d", tag, i), ia.busy_w, tab_a[i].busy);
            chk($sformatf("%s_done%0d", tag, i), ia.done, tab_a[i].done);
            chk($sformatf("%s_wdata%0d", tag, i), ia.wdata, '0);
            if (tab_a[i].busy) chk($sformatf("%s_ren%0d", tag, i), ia.ren, '0);
            next_cycle();
        end
    endtask

    task automatic run_tab_b(input string tag);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("%s_wen%0d", tag, i), ib.wen, tab_b[i].wen);
            chk($sformatf("%s_waddr%0d", tag, i), ib.waddr, tab_b[i].waddr);
            chk($sformatf("%s_busy%0d", tag, i), ib.busy_w, tab_b[i].busy);
            chk($sformatf("%s_done%0d", tag, i), ib.done, tab_b[i].done);
            if (i == 1 || i == 2) chk($sformatf("%s_wdata%0d", tag, i), ib.wdata, {4{INIT_B}});
            if (tab_b[i].busy) chk($sformatf("%s_ren%0d", tag, i), ib.ren, '0);
            next_cycle();
        end
    endtask

    // Bounded window: counts done pulses on dut_a and records the first one.
    task automatic watch_a(input int cycles, output int n, output int first);
        n = 0;
        first = -1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ia.done) begin
                if (first < 0) first = i;
                n++;
            end
            next_cycle();
        end
    endtask

    initial begin
        // cycle-indexed expectations from the moment START is entered
        tab_a[0] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_a[1] = '{wen: 4'b0011, waddr: 16'h008, busy: 1'b1, done: 1'b0};
        tab_a[2] = '{wen: 4'b0011, waddr: 16'h01A, busy: 1'b1, done: 1'b0};
        tab_a[3] = '{wen: 4'b0011, waddr: 16'h02C, busy: 1'b1, done: 1'b0};
        tab_a[4] = '{wen: 4'b0011, waddr: 16'h03E, busy: 1'b1, done: 1'b0};
        tab_a[5] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_a[6] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_a[7] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b0, done: 1'b1};
        tab_a[8] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b0, done: 1'b0};

        tab_b[0] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_b[1] = '{wen: 4'b1111, waddr: 16'h688, busy: 1'b1, done: 1'b0};
        tab_b[2] = '{wen: 4'b0011, waddr: 16'h02C, busy: 1'b1, done: 1'b0};
        tab_b[3] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_b[4] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b1, done: 1'b0};
        tab_b[5] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b0, done: 1'b1};
        tab_b[6] = '{wen: 4'b0000, waddr: 16'h000, busy: 1'b0, done: 1'b0};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ia.init = 1'b0; ia.c_ren = '0; ia.c_raddr = '0;
        ia.c_wen = '0; ia.c_waddr = '0; ia.c_wdata = '0;
        ib.init = 1'b0; ib.c_ren = '0; ib.c_raddr = '0;
        ib.c_wen = 4'b0001; ib.c_waddr = '0; ib.c_wdata = '0;

        // reset values; dut_b resets into IDLE yet must not pass c_wen through
        @(negedge clk);
        chk("rst_a_wen", ia.wen, '0);
        chk("rst_a_done", ia.done, '0);
        chk("rst_a_drop", ia.drop_err, '0);
        chk("rst_b_wen", ib.wen, '0);
        chk("rst_b_busy", ib.busy_w, '0);

        next_cycle();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        ib.c_wen = '0;
        run_tab_a("boot");

        // dut_b: init pulse, partial last beat
        ib.init = 1'b1;
        @(negedge clk);
        chk("b_pre_busy", ib.busy_w, '0);
        next_cycle();
        ib.init = 1'b0;
        run_tab_b("initb");

        // IDLE pass-through on dut_b
        ib.c_ren = 2'b01; ib.c_raddr = 6'd5;
        ib.c_wen = 4'b0001; ib.c_waddr = 12'd2; ib.c_wdata = 128'd7;
        @(negedge clk);
        chk("pt_ren", ib.ren, 2'b01);
        chk("pt_raddr", ib.raddr, 6'd5);
        chk("pt_wen", ib.wen, 4'b0001);
        chk("pt_waddr", ib.waddr, 12'd2);
        chk("pt_wdata", ib.wdata, 128'd7);
        chk("pt_busy", ib.busy_w, '0);
        next_cycle();
        ib.c_ren = '0; ib.c_wen = '0; ib.c_waddr = '0; ib.c_raddr = '0; ib.c_wdata = '0;
        @(negedge clk);
        chk("pt_drop", ib.drop_err, '0);

        // client write during dut_a sweep is dropped and flagged
        next_cycle();
        ia.init = 1'b1;
        next_cycle();
        ia.init = 1'b0;
        next_cycle();
        next_cycle();
        ia.c_wen = 2'b01; ia.c_waddr = 6'd3; ia.c_wdata = 64'hA5A5A5A5;
        @(negedge clk);
        chk("drop_wen", ia.wen, 2'b11);
        chk("drop_waddr", ia.waddr, 6'h1A);
        chk("drop_wdata", ia.wdata, '0);
        chk("drop_err_early", ia.drop_err, '0);
        next_cycle();
        ia.c_wen = '0; ia.c_waddr = '0; ia.c_wdata = '0;
        @(negedge clk);
        chk("drop_err_set", ia.drop_err, 1'b1);
        next_cycle();
        watch_a(12, n_done, first_done);
        chk("drop_ndone", n_done, 1);
        chk("drop_done_at", first_done, 3);
        chk("drop_err_sticky", ia.drop_err, 1'b1);

        // new init clears drop_err; mid-sweep init is ignored
        ia.init = 1'b1;
        next_cycle();
        ia.init = 1'b0;
        @(negedge clk);
        chk("d_clear", ia.drop_err, '0);
        next_cycle();
        ia.c_ren = 1'b1;
        @(negedge clk);
        chk("d_ren_blocked", ia.ren, '0);
        next_cycle();
        ia.c_ren = 1'b0;
        @(negedge clk);
        chk("d_drop_set", ia.drop_err, 1'b1);
        next_cycle();
        ia.init = 1'b1;
        @(negedge clk);
        chk("d_beat2", ia.waddr, 6'h2C);
        next_cycle();
        ia.init = 1'b0;
        @(negedge clk);
        chk("d_beat3", ia.waddr, 6'h3E);
        next_cycle();
        watch_a(14, n_done, first_done);
        chk("d_ndone", n_done, 1);
        chk("d_done_at", first_done, 2);
        chk("d_drop_kept", ia.drop_err, 1'b1);

        // reset at SWEEP beat 1, then full restart
        ia.init = 1'b1;
        next_cycle();
        ia.init = 1'b0;
        next_cycle();
        next_cycle();
        rst_a_n = 1'b0;
        #1;
        chk("r_wen", ia.wen, '0);
        chk("r_drop", ia.drop_err, '0);
        chk("r_done", ia.done, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        run_tab_a("rerun");

        // init in IDLE alongside a client write: write passes, sweep starts next
        ia.init = 1'b1; ia.c_wen = 2'b10; ia.c_waddr = 6'd48; ia.c_wdata = {32'd9, 32'd0};
        @(negedge clk);
        chk("g_wen", ia.wen, 2'b10);
        chk("g_waddr", ia.waddr, 6'd48);
        chk("g_wdata", ia.wdata, {32'd9, 32'd0});
        chk("g_busy", ia.busy_w, '0);
        next_cycle();
        ia.init = 1'b0; ia.c_wen = '0; ia.c_waddr = '0; ia.c_wdata = '0;
        @(negedge clk);
        chk("g_busy1", ia.busy_w, 1'b1);
        chk("g_wen1", ia.wen, '0);
        chk("g_drop", ia.drop_err, '0);
        next_cycle();
        watch_a(12, n_done, first_done);
        chk("g_ndone", n_done, 1);
        chk("g_done_at", first_done, 6);

        chk("b_final_busy", ib.busy_w, '0);
        chk("b_final_drop", ib.drop_err, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
